// File: rtl/output_control.sv
// ---------------------------------------------------------------------------
// output_control
//
// Result-side partner of the serial operand loader. Takes one parallel
// snapshot of the N*N accumulator results from the systolic array, then
// streams them off-chip bit-serially on a single pin. Word 0 goes first, and
// each word is sent LSB first. The host paces the stream with read_en.
//
// Parameters
//   D_W    operand width (results are ACC_W wide, ACC_W >= 2*D_W)
//   N      array dimension; N*N result words per frame
//   ACC_W  result word width
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; aborts any frame in flight
//   in_z_flat  N*N results, word k = in_z_flat[(k+1)*ACC_W-1 -: ACC_W]
//   capture    1-cycle strobe: in_z_flat is valid this cycle
//   read_en    host shift request; low pauses the stream
//   data_out   serial result bit (registered)
//   out_valid  data_out carries a valid bit this cycle (registered)
//   full       snapshot held and not yet fully sent
//   done       1-cycle pulse on the cycle after the last bit of a frame
//   ovf        sticky: a capture arrived while a frame was still pending
//
// Configuration macro
//   OUTPUT_CONTROL_PARITY_EN  when defined, each word is followed by one
//                             even-parity bit (XOR of the word), so a frame
//                             is N*N*(ACC_W+1) valid cycles.
// ---------------------------------------------------------------------------
module output_control #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int ACC_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*N*ACC_W-1:0]   in_z_flat,
  input  logic                   capture,
  input  logic                   read_en,
  output logic                   data_out,
  output logic                   out_valid,
  output logic                   full,
  output logic                   done,
  output logic                   ovf
);

  localparam int NW   = N * N;
  localparam int WC_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int BC_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;

  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NW - 1);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(ACC_W - 1);

  // Result words must be able to hold a full operand product.
  if (ACC_W < 2 * D_W) begin : g_width_check
    $error("output_control: ACC_W must be at least 2*D_W");
  end

  // FLUSH is the cycle in which the final bit is visible on data_out; the
  // transition out of it raises done, so the done cycle itself is spent in
  // IDLE and a new capture there is accepted.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    SHIFT  = 3'd2,
`ifdef OUTPUT_CONTROL_PARITY_EN
    PARITY = 3'd3,
`endif
    FLUSH  = 3'd4
  } state_t;

  state_t               state_reg;
  logic [NW*ACC_W-1:0]  buffer_reg;
  logic [WC_W-1:0]      word_cnt_reg;
  logic [BC_W-1:0]      bit_cnt_reg;
  logic                 data_out_reg;
  logic                 out_valid_reg;
  logic                 full_reg;
  logic                 done_reg;
  logic                 ovf_reg;

  // Split the snapshot into words so the current word is a simple array read.
  logic [ACC_W-1:0] words [NW];

  for (genvar gi = 0; gi < NW; gi++) begin : g_words
    assign words[gi] = buffer_reg[gi*ACC_W +: ACC_W];
  end

  logic [ACC_W-1:0] cur_word;
  logic             cur_bit;
  logic             last_bit;
  logic             last_word;

  assign cur_word  = words[word_cnt_reg];
  assign cur_bit   = cur_word[bit_cnt_reg];
  assign last_bit  = (bit_cnt_reg == LAST_BIT);
  assign last_word = (word_cnt_reg == LAST_WORD);

`ifdef OUTPUT_CONTROL_PARITY_EN
  logic cur_parity;
  assign cur_parity = ^cur_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      buffer_reg    <= '0;
      word_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      data_out_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      full_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // read_en is deliberately ignored here, even alongside capture.
          out_valid_reg <= 1'b0;
          if (capture) begin
            buffer_reg   <= in_z_flat;
            full_reg     <= 1'b1;
            ovf_reg      <= 1'b0;
            word_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= READY;
          end
        end

        // READY and SHIFT share the emit path: the first read_en in READY
        // sends bit 0 of word 0 straight away, so it is visible next cycle.
        READY, SHIFT: begin
          if (capture) begin
            ovf_reg <= 1'b1;
          end
          out_valid_reg <= read_en;
          if (read_en) begin
            data_out_reg <= cur_bit;
            state_reg    <= SHIFT;
            if (last_bit) begin
              bit_cnt_reg <= '0;
`ifdef OUTPUT_CONTROL_PARITY_EN
              // The word counter advances after the parity bit is sent.
              state_reg <= PARITY;
`else
              if (last_word) begin
                word_cnt_reg <= '0;
                state_reg    <= FLUSH;
              end else begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
              end
`endif
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end

`ifdef OUTPUT_CONTROL_PARITY_EN
        PARITY: begin
          if (capture) begin
            ovf_reg <= 1'b1;
          end
          out_valid_reg <= read_en;
          if (read_en) begin
            data_out_reg <= cur_parity;
            if (last_word) begin
              word_cnt_reg <= '0;
              state_reg    <= FLUSH;
            end else begin
              word_cnt_reg <= word_cnt_reg + 1'b1;
              state_reg    <= SHIFT;
            end
          end
        end
`endif

        FLUSH: begin
          // Final bit is on the pin this cycle; close the frame regardless
          // of read_en since nothing is left to send.
          if (capture) begin
            ovf_reg <= 1'b1;
          end
          out_valid_reg <= 1'b0;
          full_reg      <= 1'b0;
          done_reg      <= 1'b1;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_out_reg;
  assign out_valid = out_valid_reg;
  assign full      = full_reg;
  assign done      = done_reg;
  assign ovf       = ovf_reg;

endmodule
